fpu_issue_ctrl: RTL and testbench

//  Issuing side of the FPU start/done protocol: accepts one FP op from the execute stage (valid/ready),

---
 rtl/fpu_issue_ctrl_pkg.sv | 53 +++++
 rtl/fpu_issue_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: FSM state encoding,
// exception flag bit positions and rounding-mode constants.
package fpu_issue_ctrl_pkg;

  // state    | meaning
  // ---------+----------------------------------------------------------
  // ST_IDLE  | ready for a new op from execute, req_ready high
  // ST_ISSUE | one-cycle fpu_start pulse, operands already registered
  // ST_WAIT  | op in flight, waiting for fpu_done
  // ST_RESP  | result held on rsp_* until writeback handshakes
  // ST_DRAIN | op was flushed while in flight; swallow its fpu_done
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam int OP_W    = 5;
  localparam int RM_W    = 3;
  localparam int REG_W   = 5;
  localparam int FLAGS_W = 5;

  // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector.
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Instruction rm field value that selects the CSR frm.
  localparam logic [RM_W-1:0] RM_DYN = 3'b111;

  // Next value of the sticky fflags accumulator. A CSR write in the same
  // cycle is ordered after the retiring op, so it wipes that op's flags too.
  function automatic logic [FLAGS_W-1:0] fflags_next(
    input logic [FLAGS_W-1:0] acc,
    input logic [FLAGS_W-1:0] flags,
    input logic               deliver,
    input logic               clr
  );
    logic [FLAGS_W-1:0] v;
    v = acc;
    if (clr) begin
      v = '0;
    end else if (deliver) begin
      v = acc | flags;
    end
    return v;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl.sv
// Issue side of the FPU start/done protocol. Accepts one op from execute,
// launches it with a single start pulse, keeps the operands stable while the
// FPU works, and presents result/rd/flags to writeback. Maintains the sticky
// fflags for the CSR file and a start->done watchdog.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OP_W-1:0]     req_op,
  input  logic [RM_W-1:0]     req_rm,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  input  logic                req_rs2_lsb,
  input  logic [REG_W-1:0]    req_rd,
  input  logic [RM_W-1:0]     csr_frm,
  input  logic                flush,

  output logic                fpu_start,
  output logic [OP_W-1:0]     fpu_op,
  output logic [RM_W-1:0]     fpu_rm,
  output logic [RM_W-1:0]     fpu_dyn_rm,
  output logic [DATA_W-1:0]   fpu_a,
  output logic [DATA_W-1:0]   fpu_b,
  output logic                fpu_rs2_lsb,
  input  logic [DATA_W-1:0]   fpu_result,
  input  logic                fpu_done,
  input  logic [FLAGS_W-1:0]  fpu_flags,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_result,
  output logic [REG_W-1:0]    rsp_rd,
  output logic [FLAGS_W-1:0]  rsp_flags,

  output logic [FLAGS_W-1:0]  fflags_acc,
  input  logic                fflags_clr,
  output logic                busy,
  output logic                timeout_err
);

  // A zero TIMEOUT_CYC disables the watchdog; keep a 1-bit counter so the
  // declarations stay legal.
  localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WD_W-1:0] WD_LOAD =
    (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

  state_e              r_state;
  state_e              w_state_nxt;

  logic [OP_W-1:0]     r_op;
  logic [RM_W-1:0]     r_rm;
  logic [RM_W-1:0]     r_dyn_rm;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_rs2_lsb;
  logic [REG_W-1:0]    r_rd;

  logic [DATA_W-1:0]   r_rsp_result;
  logic [REG_W-1:0]    r_rsp_rd;
  logic [FLAGS_W-1:0]  r_rsp_flags;
  logic [FLAGS_W-1:0]  r_fflags_acc;
  logic                r_timeout_err;

  logic [WD_W-1:0]     r_wd_cnt;

  logic                w_accept;
  logic                w_capture;
  logic                w_rsp_hs;
  logic                w_wd_tc;
  logic                w_wd_fire;
  logic                w_in_flight;

  // The down-counter is loaded during ISSUE so that cycle k after the start
  // pulse holds TIMEOUT_CYC-k; reaching 1 means the next cycle is the limit.
  assign w_in_flight = (r_state == ST_WAIT) || (r_state == ST_DRAIN);
  assign w_wd_tc     = (TIMEOUT_CYC != 0) && (r_wd_cnt <= WD_ONE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode, handshake strobes and state-derived outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_rsp_hs    = 1'b0;
    w_wd_fire   = 1'b0;
    req_ready   = 1'b0;
    fpu_start   = 1'b0;
    rsp_valid   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !flush) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // The FPU is launched regardless of flush; a flushed op must drain.
        fpu_start   = 1'b1;
        w_state_nxt = flush ? ST_DRAIN : ST_WAIT;
      end

      ST_WAIT: begin
        if (fpu_done) begin
          if (flush) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = ST_RESP;
          end
        end else if (w_wd_tc) begin
          w_wd_fire   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (flush) begin
          w_state_nxt = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (fpu_done) begin
          w_state_nxt = ST_IDLE;
        end else if (w_wd_tc) begin
          w_wd_fire   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else if (rsp_ready) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request capture: held from accept until the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op      <= '0;
      r_rm      <= '0;
      r_dyn_rm  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_rs2_lsb <= 1'b0;
      r_rd      <= '0;
    end else if (w_accept) begin
      r_op      <= req_op;
      r_rm      <= req_rm;
      r_dyn_rm  <= csr_frm;
      r_a       <= req_a;
      r_b       <= req_b;
      r_rs2_lsb <= req_rs2_lsb;
      r_rd      <= req_rd;
    end
  end

  // Response capture on fpu_done; held through the writeback stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_result <= '0;
      r_rsp_rd     <= '0;
      r_rsp_flags  <= '0;
    end else if (w_capture) begin
      r_rsp_result <= fpu_result;
      r_rsp_rd     <= r_rd;
      r_rsp_flags  <= fpu_flags;
    end
  end

  // Sticky exception flags, updated only by delivered responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fflags_acc <= '0;
    end else begin
      r_fflags_acc <= fflags_next(r_fflags_acc, r_rsp_flags, w_rsp_hs, fflags_clr);
    end
  end

  // Watchdog down-counter, reloaded on every start pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_wd_cnt <= WD_LOAD;
    end else if (w_in_flight && (r_wd_cnt != '0)) begin
      r_wd_cnt <= r_wd_cnt - WD_ONE;
    end
  end

  // Timeout indication stays set until the next reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout_err <= 1'b0;
    end else if (w_wd_fire) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign fpu_op      = r_op;
  assign fpu_rm      = r_rm;
  assign fpu_dyn_rm  = r_dyn_rm;
  assign fpu_a       = r_a;
  assign fpu_b       = r_b;
  assign fpu_rs2_lsb = r_rs2_lsb;
  assign rsp_result  = r_rsp_result;
  assign rsp_rd      = r_rsp_rd;
  assign rsp_flags   = r_rsp_flags;
  assign fflags_acc  = r_fflags_acc;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: a behavioural FPU responder with programmable
// latency plus directed and randomized scenarios checked against a
// transaction-level model of the protocol.
module tb_fpu_issue_ctrl;

  localparam int DW = 32;
  localparam int TO = 64;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_op;
  logic [2:0]    req_rm;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic          req_rs2_lsb;
  logic [4:0]    req_rd;
  logic [2:0]    csr_frm;
  logic          flush;
  logic          fpu_start;
  logic [4:0]    fpu_op;
  logic [2:0]    fpu_rm;
  logic [2:0]    fpu_dyn_rm;
  logic [DW-1:0] fpu_a;
  logic [DW-1:0] fpu_b;
  logic          fpu_rs2_lsb;
  logic [DW-1:0] fpu_result;
  logic          fpu_done;
  logic [4:0]    fpu_flags;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic [4:0]    rsp_rd;
  logic [4:0]    rsp_flags;
  logic [4:0]    fflags_acc;
  logic          fflags_clr;
  logic          busy;
  logic          timeout_err;

  int            total;
  int            bad;
  logic [4:0]    exp_acc;

  // responder control
  int            fpu_lat;
  logic          fpu_mute;
  logic [DW-1:0] fpu_res_v;
  logic [4:0]    fpu_flg_v;
  logic [DW-1:0] exp_a;
  logic [DW-1:0] exp_b;
  logic          chk_hold;

  fpu_issue_ctrl #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
    .req_a(req_a), .req_b(req_b), .req_rs2_lsb(req_rs2_lsb), .req_rd(req_rd),
    .csr_frm(csr_frm), .flush(flush),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_dyn_rm(fpu_dyn_rm),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_rs2_lsb(fpu_rs2_lsb),
    .fpu_result(fpu_result), .fpu_done(fpu_done), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_rd(rsp_rd), .rsp_flags(rsp_flags),
    .fflags_acc(fflags_acc), .fflags_clr(fflags_clr),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [4:0] op, input logic [2:0] rm, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic rs2, input logic [4:0] rd,
                           input logic [2:0] frm);
    req_op = op; req_rm = rm; req_a = a; req_b = b;
    req_rs2_lsb = rs2; req_rd = rd; csr_frm = frm;
    exp_a = a; exp_b = b;
    req_valid = 1'b1;
  endtask

  // Scramble request inputs after accept so capture is really exercised.
  task automatic release_req();
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom;
    req_op = 5'($urandom); req_rm = 3'($urandom); req_rd = 5'($urandom);
    csr_frm = 3'($urandom); req_rs2_lsb = 1'($urandom);
  endtask

  // FPU model: done fpu_lat cycles after the start pulse, operands must hold.
  initial begin
    fpu_done = 1'b0; fpu_result = '0; fpu_flags = '0;
    forever begin
      @(posedge clk); #1;
      if (fpu_start === 1'b1 && !fpu_mute) begin
        for (int k = 1; k <= fpu_lat; k++) begin
          @(posedge clk); #1;
          if (chk_hold) begin
            total++;
            if (fpu_a !== exp_a || fpu_b !== exp_b) begin
              bad++;
              $display("FAIL operand_hold k=%0d got a=%h b=%h want a=%h b=%h",
                       k, fpu_a, fpu_b, exp_a, exp_b);
            end
          end
        end
        fpu_done = 1'b1; fpu_result = fpu_res_v; fpu_flags = fpu_flg_v;
        @(posedge clk); #1;
        fpu_done = 1'b0; fpu_result = $urandom; fpu_flags = 5'($urandom);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    #3;
    total++;
    if ({req_ready, fpu_start, busy, rsp_valid, timeout_err} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl got %b want 10000",
               {req_ready, fpu_start, busy, rsp_valid, timeout_err});
    end
    total++;
    if ({fpu_op, fpu_rm, fpu_dyn_rm, fpu_a, fpu_b, fpu_rs2_lsb, rsp_result, rsp_rd,
         rsp_flags, fflags_acc} !== '0) begin
      bad++;
      $display("FAIL reset_data got op=%h a=%h b=%h res=%h rd=%h fl=%b acc=%b want all 0",
               fpu_op, fpu_a, fpu_b, rsp_result, rsp_rd, rsp_flags, fflags_acc);
    end
    tick(); tick();
    reset = 1'b1;
    exp_acc = '0;
  endtask

  task automatic test_basic_add();
    fpu_lat = 1; fpu_res_v = 32'h4040_0000; fpu_flg_v = 5'b00000;
    drive_req(5'd0, 3'b000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd5, 3'b000);
    tick(); release_req();
    total++;
    if ({fpu_start, fpu_a, fpu_b, fpu_op} !== {1'b1, 32'h3F80_0000, 32'h4000_0000, 5'd0}) begin
      bad++;
      $display("FAIL add_issue got start=%b a=%h b=%h want start=1 a=3f800000 b=40000000",
               fpu_start, fpu_a, fpu_b);
    end
    tick();
    total++;
    if ({fpu_start, rsp_valid} !== 2'b00) begin
      bad++;
      $display("FAIL add_pulse got start=%b rsp_valid=%b want 0 0", fpu_start, rsp_valid);
    end
    tick();
    rsp_ready = 1'b1;
    total++;
    if ({rsp_valid, rsp_result, rsp_rd} !== {1'b1, 32'h4040_0000, 5'd5}) begin
      bad++;
      $display("FAIL add_rsp got v=%b res=%h rd=%0d want v=1 res=40400000 rd=5",
               rsp_valid, rsp_result, rsp_rd);
    end
    tick();
    rsp_ready = 1'b0;
    total++;
    if ({req_ready, busy, fflags_acc} !== {1'b1, 1'b0, exp_acc}) begin
      bad++;
      $display("FAIL add_done got ready=%b busy=%b acc=%b want 1 0 %b",
               req_ready, busy, fflags_acc, exp_acc);
    end
  endtask

  task automatic test_div_stall();
    int n;
    fpu_lat = 20; fpu_res_v = 32'h7F80_0000; fpu_flg_v = 5'b01000;
    drive_req(5'd3, 3'b111, 32'h3F80_0000, 32'h0000_0000, 1'b0, 5'd9, 3'b010);
    tick(); release_req();
    total++;
    if ({fpu_start, fpu_rm, fpu_dyn_rm} !== {1'b1, 3'b111, 3'b010}) begin
      bad++;
      $display("FAIL div_issue got start=%b rm=%b dyn=%b want 1 111 010",
               fpu_start, fpu_rm, fpu_dyn_rm);
    end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin tick(); n++; end
    total++;
    if (n != 21) begin
      bad++;
      $display("FAIL div_latency got %0d cycles want 21", n);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({rsp_valid, req_ready, rsp_result, rsp_flags, rsp_rd} !==
          {1'b1, 1'b0, 32'h7F80_0000, 5'b01000, 5'd9}) begin
        bad++;
        $display("FAIL div_stall i=%0d got v=%b rdy=%b res=%h fl=%b rd=%0d want 1 0 7f800000 01000 9",
                 i, rsp_valid, req_ready, rsp_result, rsp_flags, rsp_rd);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_acc = exp_acc | 5'b01000;
    total++;
    if ({req_ready, fflags_acc} !== {1'b1, exp_acc}) begin
      bad++;
      $display("FAIL div_acc got ready=%b acc=%b want 1 %b", req_ready, fflags_acc, exp_acc);
    end
  endtask

  task automatic test_flush();
    int viol;
    // flush while waiting on a 20-cycle op
    fpu_lat = 20; fpu_res_v = $urandom; fpu_flg_v = 5'b11111;
    drive_req(5'd3, 3'b001, $urandom, $urandom, 1'b0, 5'd7, 3'b000);
    tick(); release_req();
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    viol = 0;
    for (int i = 6; i <= 20; i++) begin
      if ({rsp_valid, req_ready, busy} !== 3'b001) viol++;
      tick();
    end
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL drain_hold got %0d bad cycles want 0", viol);
    end
    total++;
    if ({req_ready, rsp_valid, fflags_acc} !== {1'b1, 1'b0, exp_acc}) begin
      bad++;
      $display("FAIL drain_exit got ready=%b v=%b acc=%b want 1 0 %b",
               req_ready, rsp_valid, fflags_acc, exp_acc);
    end
    // flush in the very cycle done arrives
    fpu_lat = 3; fpu_flg_v = 5'b10101;
    drive_req(5'd1, 3'b000, $urandom, $urandom, 1'b1, 5'd2, 3'b000);
    tick(); release_req();
    for (int i = 0; i < 3; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL flush_done got ready=%b v=%b want 1 0", req_ready, rsp_valid);
    end
    // flush while the response is waiting for writeback
    fpu_lat = 1; fpu_flg_v = 5'b10101;
    drive_req(5'd1, 3'b000, $urandom, $urandom, 1'b0, 5'd3, 3'b000);
    tick(); release_req();
    tick(); tick();
    flush = 1'b1; rsp_ready = 1'b1;
    tick();
    flush = 1'b0; rsp_ready = 1'b0;
    total++;
    if ({req_ready, rsp_valid, fflags_acc} !== {1'b1, 1'b0, exp_acc}) begin
      bad++;
      $display("FAIL flush_resp got ready=%b v=%b acc=%b want 1 0 %b",
               req_ready, rsp_valid, fflags_acc, exp_acc);
    end
  endtask

  task automatic test_fflags_clr();
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    exp_acc = '0;
    fpu_lat = 1; fpu_res_v = $urandom; fpu_flg_v = 5'b10000;
    drive_req(5'd2, 3'b000, $urandom, $urandom, 1'b0, 5'd4, 3'b000);
    tick(); release_req();
    tick(); tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_acc = exp_acc | 5'b10000;
    total++;
    if (fflags_acc !== exp_acc) begin
      bad++;
      $display("FAIL clr_setup got acc=%b want %b", fflags_acc, exp_acc);
    end
    fpu_flg_v = 5'b00001;
    drive_req(5'd2, 3'b000, $urandom, $urandom, 1'b0, 5'd4, 3'b000);
    tick(); release_req();
    tick(); tick();
    rsp_ready = 1'b1; fflags_clr = 1'b1;
    tick();
    rsp_ready = 1'b0; fflags_clr = 1'b0;
    exp_acc = '0;
    total++;
    if ({fflags_acc, req_ready} !== {exp_acc, 1'b1}) begin
      bad++;
      $display("FAIL clr_wins got acc=%b ready=%b want %b 1", fflags_acc, req_ready, exp_acc);
    end
  endtask

  task automatic test_timeout();
    fpu_mute = 1'b1;
    drive_req(5'd3, 3'b000, $urandom, $urandom, 1'b0, 5'd1, 3'b000);
    tick(); release_req();
    for (int i = 1; i < TO; i++) tick();
    total++;
    if ({timeout_err, busy} !== 2'b01) begin
      bad++;
      $display("FAIL timeout_early got err=%b busy=%b at cycle %0d want 0 1",
               timeout_err, busy, TO - 1);
    end
    tick();
    total++;
    if ({timeout_err, req_ready} !== 2'b11) begin
      bad++;
      $display("FAIL timeout_fire got err=%b ready=%b at cycle %0d want 1 1",
               timeout_err, req_ready, TO);
    end
    fpu_mute = 1'b0;
    fpu_lat = 1; fpu_res_v = $urandom; fpu_flg_v = 5'b00000;
    drive_req(5'd0, 3'b000, $urandom, $urandom, 1'b0, 5'd1, 3'b000);
    tick(); release_req();
    tick(); tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if ({timeout_err, req_ready} !== 2'b11) begin
      bad++;
      $display("FAIL timeout_sticky got err=%b ready=%b want 1 1", timeout_err, req_ready);
    end
  endtask

  task automatic test_reset_midop();
    int viol;
    chk_hold = 1'b0;
    fpu_lat = 10; fpu_res_v = $urandom; fpu_flg_v = 5'b11111;
    drive_req(5'd3, 3'b000, 32'hDEAD_BEEF, $urandom, 1'b0, 5'd6, 3'b000);
    tick(); release_req();
    tick(); tick(); tick();
    reset = 1'b0;
    #2;
    total++;
    if ({busy, req_ready, timeout_err, fpu_a} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset_midop got busy=%b ready=%b err=%b a=%h want 0 1 0 0",
               busy, req_ready, timeout_err, fpu_a);
    end
    tick();
    reset = 1'b1;
    exp_acc = '0;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      if ({rsp_valid, busy} !== 2'b00) viol++;
      tick();
    end
    total++;
    if ({viol[7:0], fflags_acc} !== {8'd0, exp_acc}) begin
      bad++;
      $display("FAIL late_done got %0d bad cycles acc=%b want 0 %b", viol, fflags_acc, exp_acc);
    end
    chk_hold = 1'b1;
  endtask

  task automatic test_random();
    logic [4:0]    op, rd, fl;
    logic [2:0]    rm, frm;
    logic [DW-1:0] a, b, res;
    logic          rs2, clr;
    int            lat, stall, n, gap;
    for (int it = 0; it < 40; it++) begin
      op = 5'($urandom); rd = 5'($urandom); fl = 5'($urandom);
      rm = 3'($urandom); frm = 3'($urandom); rs2 = 1'($urandom);
      a = $urandom; b = $urandom; res = $urandom;
      lat = $urandom_range(1, 6); stall = $urandom_range(0, 3);
      gap = $urandom_range(0, 2); clr = ($urandom_range(0, 7) == 0);
      for (int g = 0; g < gap; g++) tick();
      fpu_lat = lat; fpu_res_v = res; fpu_flg_v = fl;
      drive_req(op, rm, a, b, rs2, rd, frm);
      tick(); release_req();
      total++;
      if ({fpu_start, fpu_op, fpu_rm, fpu_dyn_rm, fpu_rs2_lsb} !== {1'b1, op, rm, frm, rs2}) begin
        bad++;
        $display("FAIL rnd_issue it=%0d got start=%b op=%h rm=%b dyn=%b rs2=%b want 1 %h %b %b %b",
                 it, fpu_start, fpu_op, fpu_rm, fpu_dyn_rm, fpu_rs2_lsb, op, rm, frm, rs2);
      end
      n = 0;
      while (rsp_valid !== 1'b1 && n < lat + 8) begin tick(); n++; end
      total++;
      if (n != lat + 1) begin
        bad++;
        $display("FAIL rnd_latency it=%0d got %0d want %0d", it, n, lat + 1);
      end
      for (int s = 0; s < stall; s++) begin
        total++;
        if ({rsp_valid, req_ready, rsp_result, rsp_flags} !== {1'b1, 1'b0, res, fl}) begin
          bad++;
          $display("FAIL rnd_stall it=%0d got v=%b rdy=%b res=%h fl=%b want 1 0 %h %b",
                   it, rsp_valid, req_ready, rsp_result, rsp_flags, res, fl);
        end
        tick();
      end
      rsp_ready = 1'b1; fflags_clr = clr;
      total++;
      if ({rsp_valid, rsp_result, rsp_flags, rsp_rd} !== {1'b1, res, fl, rd}) begin
        bad++;
        $display("FAIL rnd_rsp it=%0d got v=%b res=%h fl=%b rd=%0d want 1 %h %b %0d",
                 it, rsp_valid, rsp_result, rsp_flags, rsp_rd, res, fl, rd);
      end
      tick();
      rsp_ready = 1'b0; fflags_clr = 1'b0;
      exp_acc = clr ? 5'b00000 : (exp_acc | fl);
      total++;
      if ({fflags_acc, req_ready} !== {exp_acc, 1'b1}) begin
        bad++;
        $display("FAIL rnd_acc it=%0d got acc=%b ready=%b want %b 1", it, fflags_acc, req_ready, exp_acc);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; exp_acc = '0;
    fpu_lat = 1; fpu_mute = 1'b0; fpu_res_v = '0; fpu_flg_v = '0;
    exp_a = '0; exp_b = '0; chk_hold = 1'b1;
    reset = 1'b0; req_valid = 1'b0; req_op = '0; req_rm = '0; req_a = '0; req_b = '0;
    req_rs2_lsb = 1'b0; req_rd = '0; csr_frm = '0; flush = 1'b0;
    rsp_ready = 1'b0; fflags_clr = 1'b0;
    #1;
    test_reset();
    test_basic_add();
    test_div_stall();
    test_flush();
    test_fflags_clr();
    test_timeout();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
